// File: rtl/trig_readout_scheduler.sv
`default_nettype none
// ============================================================================
// trig_readout_scheduler: pops TTC trigger words, issues one readout command
// per word, waits for completion (with timeout) and holds off before re-arming.
// Revision: 1.0
// ============================================================================
module trig_readout_scheduler #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000,
  parameter logic [7:0]  HOLDOFF_CYCLES = 8'd4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear_errors,
  input  logic         trig_valid,
  input  logic [127:0] trig_data,
  output logic         trig_ready,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic [1:0]   cmd_type,
  output logic [23:0]  cmd_trig_num,
  output logic [23:0]  cmd_event_cnt,
  output logic [4:0]   cmd_trig_type,
  output logic [43:0]  cmd_timestamp,
  input  logic         readout_done,
  output logic         acq_ready,
  output logic [2:0]   state,
  output logic [31:0]  readouts_done_cnt,
  output logic [15:0]  timeout_cnt,
  output logic         error_timeout,
  output logic         error_seq,
  output logic         error_spurious
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_HOLDOFF   = 3'd3,
    S_TIMEOUT   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [23:0] r_wait_cnt;
  logic [7:0]  r_hold_cnt;
  logic [1:0]  r_cmd_type;
  logic [23:0] r_trig_num;
  logic [23:0] r_event_cnt;
  logic [4:0]  r_trig_type;
  logic [43:0] r_timestamp;
  logic [31:0] r_done_cnt;
  logic [15:0] r_timeout_cnt;
  logic        r_err_timeout;
  logic        r_err_seq;
  logic        r_err_spurious;
  logic        r_seq_armed;
  logic [23:0] r_prev_num;

  logic w_trig_ready;
  logic w_pop;
  logic w_handshake;
  logic w_done_ok;
  logic w_expire;
  logic w_hold_end;
  logic w_seq_bad;
  logic w_unused_bits;

  // Gated by reset so no word is popped (and lost) while the block is held in reset.
  assign w_trig_ready = (r_state == S_IDLE) & enable & ~reset;
  assign w_pop        = w_trig_ready & trig_valid;
  assign w_handshake  = (r_state == S_ISSUE) & cmd_ready;
  assign w_done_ok    = (r_state == S_WAIT_DONE) & readout_done;
  assign w_expire     = (r_state == S_WAIT_DONE) & ~readout_done &
                        (r_wait_cnt == TIMEOUT_CYCLES - 24'd1);
  assign w_hold_end   = (r_state == S_HOLDOFF) & (r_hold_cnt == HOLDOFF_CYCLES - 8'd1);
  assign w_seq_bad    = r_seq_armed & (trig_data[67:44] != r_prev_num + 24'd1);
  assign w_unused_bits = ^{trig_data[127:103], trig_data[101:98]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_pop) w_next = S_ISSUE;
      S_ISSUE:     if (cmd_ready) w_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (readout_done)  w_next = (HOLDOFF_CYCLES == 8'd0) ? S_IDLE : S_HOLDOFF;
        else if (w_expire) w_next = S_TIMEOUT;
      end
      S_HOLDOFF:   if (w_hold_end) w_next = S_IDLE;
      S_TIMEOUT:   if (clear_errors) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt     <= '0;
      r_hold_cnt     <= '0;
      r_cmd_type     <= '0;
      r_trig_num     <= '0;
      r_event_cnt    <= '0;
      r_trig_type    <= '0;
      r_timestamp    <= '0;
      r_done_cnt     <= '0;
      r_timeout_cnt  <= '0;
      r_err_timeout  <= 1'b0;
      r_err_seq      <= 1'b0;
      r_err_spurious <= 1'b0;
      r_seq_armed    <= 1'b0;
      r_prev_num     <= '0;
    end else begin
      if (w_handshake)                    r_wait_cnt <= '0;
      else if (r_state == S_WAIT_DONE)    r_wait_cnt <= r_wait_cnt + 24'd1;

      if (w_done_ok)                      r_hold_cnt <= '0;
      else if (r_state == S_HOLDOFF)      r_hold_cnt <= r_hold_cnt + 8'd1;

      if (w_pop) begin
        r_cmd_type  <= trig_data[97] ? 2'd1 : (trig_data[102] ? 2'd2 : 2'd0);
        r_trig_num  <= trig_data[67:44];
        r_event_cnt <= trig_data[91:68];
        r_trig_type <= trig_data[96:92];
        r_timestamp <= trig_data[43:0];
        r_prev_num  <= trig_data[67:44];
      end

      if (w_done_ok) r_done_cnt <= r_done_cnt + 32'd1;
      if (w_expire && r_timeout_cnt != 16'hFFFF) r_timeout_cnt <= r_timeout_cnt + 16'd1;

      r_err_timeout <= (w_next == S_TIMEOUT);

      // A word popped on the clear cycle becomes the new sequence reference.
      if (clear_errors) begin
        r_err_seq      <= 1'b0;
        r_err_spurious <= 1'b0;
        r_seq_armed    <= w_pop;
      end else begin
        if (w_pop) begin
          r_seq_armed <= 1'b1;
          if (w_seq_bad) r_err_seq <= 1'b1;
        end
        if (readout_done && r_state != S_WAIT_DONE) r_err_spurious <= 1'b1;
      end
    end
  end

  assign trig_ready        = w_trig_ready;
  assign cmd_valid         = (r_state == S_ISSUE);
  assign cmd_type          = r_cmd_type;
  assign cmd_trig_num      = r_trig_num;
  assign cmd_event_cnt     = r_event_cnt;
  assign cmd_trig_type     = r_trig_type;
  assign cmd_timestamp     = r_timestamp;
  assign acq_ready         = (r_state == S_IDLE) & enable & ~r_err_timeout & ~reset;
  assign state             = r_state;
  assign readouts_done_cnt = r_done_cnt;
  assign timeout_cnt       = r_timeout_cnt;
  assign error_timeout     = r_err_timeout;
  assign error_seq         = r_err_seq;
  assign error_spurious    = r_err_spurious;

endmodule
`default_nettype wire
